// File: rtl/vco_log_arbiter.sv
// Round-robin arbiter sharing one natural_log unit between NUM_CH VCO voices.
// Grants one voice per cycle and returns each result tagged with its channel id.
module vco_log_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int LOG_LATENCY = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 I_RSTn,
   input  logic [NUM_CH-1:0]    req,
   input  logic [NUM_CH*24-1:0] req_data,
   output logic [NUM_CH-1:0]    ack,
   output logic [23:0]          log_in,
   input  logic [11:0]          log_out,
   output logic                 rsp_valid,
   output logic [CH_W-1:0]      rsp_ch,
   output logic [11:0]          rsp_data
);

   logic [CH_W-1:0]   ptr_r;
   logic [CH_W-1:0]   ptr_nxt_s;
   logic [CH_W:0]     scan_sum_s;
   logic [CH_W:0]     scan_s;
   logic              found_s;
   logic [CH_W-1:0]   grant_idx_s;
   logic [NUM_CH-1:0] grant_s;
   logic [23:0]       grant_data_s;
   logic [23:0]       log_in_r;
   logic              tag_vld_r [0:LOG_LATENCY];
   logic [CH_W-1:0]   tag_ch_r  [0:LOG_LATENCY];
   logic              rsp_valid_r;
   logic [CH_W-1:0]   rsp_ch_r;
   logic [11:0]       rsp_data_r;

   // Rotating-priority scan starting at ptr; first requester found wins.
   always_comb begin
      found_s      = 1'b0;
      grant_idx_s  = '0;
      grant_s      = '0;
      grant_data_s = 24'h000000;
      scan_sum_s   = '0;
      scan_s       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scan_sum_s = {1'b0, ptr_r} + (CH_W+1)'(i);
         scan_s     = (scan_sum_s >= (CH_W+1)'(NUM_CH)) ? scan_sum_s - (CH_W+1)'(NUM_CH) : scan_sum_s;
         if (!found_s && req[scan_s[CH_W-1:0]]) begin
            found_s     = 1'b1;
            grant_idx_s = scan_s[CH_W-1:0];
         end else begin
            found_s     = found_s;
         end
      end
      if (found_s) begin
         grant_s[grant_idx_s] = 1'b1;
         grant_data_s         = req_data[24*int'(grant_idx_s) +: 24];
      end else begin
         grant_s              = '0;
      end
   end

   // Pointer advances past the winner, wrapping at the last channel.
   always_comb begin
      ptr_nxt_s = '0;
      if (grant_idx_s == CH_W'(NUM_CH-1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = grant_idx_s + CH_W'(1);
      end
   end

   // Grant is suppressed while reset is held so no voice sees a phantom transfer.
   always_comb begin
      ack = '0;
      if (I_RSTn) begin
         ack = grant_s;
      end else begin
         ack = '0;
      end
   end

   // Pointer and shared operand register update only on a grant.
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         ptr_r    <= '0;
         log_in_r <= 24'h000000;
      end else if (found_s) begin
         ptr_r    <= ptr_nxt_s;
         log_in_r <= grant_data_s;
      end
   end

   // Channel tags travel alongside the log unit's latency so results can be labelled.
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         for (int j = 0; j <= LOG_LATENCY; j++) begin
            tag_vld_r[j] <= 1'b0;
            tag_ch_r[j]  <= '0;
         end
      end else begin
         tag_vld_r[0] <= found_s;
         tag_ch_r[0]  <= grant_idx_s;
         for (int j = 1; j <= LOG_LATENCY; j++) begin
            tag_vld_r[j] <= tag_vld_r[j-1];
            tag_ch_r[j]  <= tag_ch_r[j-1];
         end
      end
   end

   // Response capture; channel and data hold between pulses.
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         rsp_valid_r <= 1'b0;
         rsp_ch_r    <= '0;
         rsp_data_r  <= 12'h000;
      end else begin
         rsp_valid_r <= tag_vld_r[LOG_LATENCY];
         if (tag_vld_r[LOG_LATENCY]) begin
            rsp_ch_r   <= tag_ch_r[LOG_LATENCY];
            rsp_data_r <= log_out;
         end
      end
   end

   assign log_in    = log_in_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_ch    = rsp_ch_r;
   assign rsp_data  = rsp_data_r;

endmodule
